trng_byte_packer: RTL

// - Downstream stage of the ring-oscillator TRNG. Samples the free-running oscillator bit and

---
 rtl/trng_byte_packer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/trng_byte_packer.sv
// trng_byte_packer: samples the ring-oscillator bit, debiases it with a von Neumann
// extractor, packs the bits MSB-first into bytes and offers them on a valid/ready port.
// Optional repetition-count health test is compiled in with `define TRNG_HEALTH_EN.
module trng_byte_packer #(
    parameter int unsigned SAMPLE_DIV = 4,
    parameter int unsigned REP_LIMIT  = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       raw_in,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       overrun,
    output logic       health_fail
);

    localparam int unsigned DIV_W = $clog2(SAMPLE_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

    typedef enum logic {
        ST_FIRST  = 1'b0,
        ST_SECOND = 1'b1
    } vn_state_t;

    // Elaboration-time guard against illegal parameter values
    if (SAMPLE_DIV < 1 || REP_LIMIT < 2) begin : g_param_check
        $error("trng_byte_packer: SAMPLE_DIV must be >=1 and REP_LIMIT >=2");
    end

    logic             sync1;
    logic             s_bit;
    logic [DIV_W-1:0] div_cnt;
    logic             strobe_c;
    vn_state_t        state;
    vn_state_t        state_next;
    logic             b0;
    logic             b0_next;
    logic             emit_c;
    logic             byte_done_c;
    logic             gate_c;
    logic [7:0]       shreg;
    logic [2:0]       bit_cnt;

    // Two-flop synchroniser for the asynchronous oscillator output
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            s_bit <= 1'b0;
        end else begin
            sync1 <= raw_in;
            s_bit <= sync1;
        end
    end

    // Sample-rate divider; held at zero while sampling is disabled
    always_ff @(posedge clk) begin
        if (rst || !en || div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign strobe_c = en && (div_cnt == DIV_LAST);

`ifdef TRNG_HEALTH_EN
    localparam int unsigned REP_W = $clog2(REP_LIMIT + 1);
    localparam logic [REP_W-1:0] REP_MAX = REP_W'(REP_LIMIT);

    logic [REP_W-1:0] rep_cnt;
    logic [REP_W-1:0] rep_next;
    logic             rep_prev;

    // Run length of identical samples; a count of zero means no sample seen yet
    always_comb begin
        rep_next = rep_cnt;
        if (strobe_c) begin
            if (rep_cnt == '0 || s_bit != rep_prev) begin
                rep_next = REP_W'(1);
            end else if (rep_cnt != REP_MAX) begin
                rep_next = rep_cnt + REP_W'(1);
            end
        end
    end

    // Repetition counter state and sticky failure flag
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt     <= '0;
            rep_prev    <= 1'b0;
            health_fail <= 1'b0;
        end else begin
            rep_cnt <= rep_next;
            if (strobe_c) begin
                rep_prev <= s_bit;
            end
            if (rep_next == REP_MAX) begin
                health_fail <= 1'b1;
            end
        end
    end

    assign gate_c = health_fail;
`else
    assign health_fail = 1'b0;
    assign gate_c      = 1'b0;
`endif

    // Extractor state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_FIRST;
            b0    <= 1'b0;
        end else begin
            state <= state_next;
            b0    <= b0_next;
        end
    end

    // Extractor next state: latch first sample, emit it on an unequal second sample
    always_comb begin
        state_next = state;
        b0_next    = b0;
        emit_c     = 1'b0;
        if (!en) begin
            state_next = ST_FIRST;
        end else if (strobe_c) begin
            case (state)
                ST_FIRST: begin
                    b0_next    = s_bit;
                    state_next = ST_SECOND;
                end
                ST_SECOND: begin
                    emit_c     = (b0 != s_bit) && !gate_c;
                    state_next = ST_FIRST;
                end
                default: state_next = ST_FIRST;
            endcase
        end
    end

    assign byte_done_c = emit_c && (bit_cnt == 3'd7);

    // Bit packer: first emitted bit ends up as the MSB
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg   <= 8'h00;
            bit_cnt <= 3'd0;
        end else if (emit_c) begin
            shreg   <= {shreg[6:0], b0};
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    // Output holding register with valid/ready handshake and overrun pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (byte_done_c) begin
                if (!tx_valid || tx_ready) begin
                    tx_data  <= {shreg[6:0], b0};
                    tx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (tx_valid && tx_ready) begin
                tx_valid <= 1'b0;
            end
        end
    end

endmodule
